// File: rtl/ahb_gpio_pkg.sv
// rtl/ahb_gpio_pkg.sv - shared register offsets, HTRANS encodings and parity helper
package ahb_gpio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_DIR    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Returns the XOR of all 17 bits against sel: a generated parity bit when
    // bit 16 is zero, and a mismatch flag when checking a full received word.
    function automatic logic parity17(input logic [16:0] data, input logic sel);
        return (^data) ^ sel;
    endfunction

endpackage

// File: rtl/gpio_parity_chk.sv
// rtl/gpio_parity_chk.sv - GPIOIN synchroniser with parity check and sticky flag (AHBGPIO_PARITY_EN)
module gpio_parity_chk
    import ahb_gpio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] gpio_in,
    input  logic        sel,
    input  logic        clr,
    output logic [15:0] pin_data,
    output logic        parity_err,
    output logic        sticky
);

    logic [16:0] sync1;
    logic [16:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    assign pin_data = sync2[15:0];

`ifdef AHBGPIO_PARITY_EN
    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            parity_err <= parity17(sync2, sel);
            sticky     <= parity_err | (sticky & ~clr);
        end
    end
`else
    assign parity_err = 1'b0;
    assign sticky     = 1'b0;

    logic unused_parity;
    assign unused_parity = ^{sync2[16], sel, clr};
`endif

endmodule

// File: rtl/ahb_gpio_parity.sv
// rtl/ahb_gpio_parity.sv - AHB-Lite 16-bit GPIO slave with parity lane (AHBGPIO_PARITY_EN)
module ahb_gpio_parity
    import ahb_gpio_pkg::*;
#(
    parameter logic [15:0] RESET_DIR = 16'h0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic [16:0] GPIOIN,
    output logic [16:0] GPIOOUT,
    input  logic        PARITYSEL,
    output logic        PARITYERR
);

    logic        accept;
    logic        act_q;
    logic        wr_q;
    logic [1:0]  addr_q;
    logic [15:0] dout;
    logic [15:0] dir;
    logic [15:0] out_data;
    logic [15:0] pin_data;
    logic        sticky;
    logic        wr_phase;
    logic        status_clr;

    assign accept = HSEL & HREADY &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 2'd0;
        end else begin
            act_q <= accept;
            if (accept) begin
                wr_q   <= HWRITE;
                addr_q <= HADDR[3:2];
            end
        end
    end

    assign wr_phase   = act_q & wr_q;
    assign status_clr = wr_phase & (addr_q == ADDR_STATUS) & HWDATA[0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout <= 16'h0000;
            dir  <= RESET_DIR;
        end else if (wr_phase) begin
            if (addr_q == ADDR_DATA) dout <= HWDATA[15:0];
            if (addr_q == ADDR_DIR)  dir  <= HWDATA[15:0];
        end
    end

    gpio_parity_chk u_chk (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .gpio_in    (GPIOIN),
        .sel        (PARITYSEL),
        .clr        (status_clr),
        .pin_data   (pin_data),
        .parity_err (PARITYERR),
        .sticky     (sticky)
    );

    always_comb begin
        HRDATA = 32'h0;
        if (act_q && !wr_q) begin
            case (addr_q)
                ADDR_DATA:   HRDATA = {16'h0, pin_data};
                ADDR_DIR:    HRDATA = {16'h0, dir};
                ADDR_STATUS: HRDATA = {30'h0, PARITYERR, sticky};
                default:     HRDATA = 32'h0;
            endcase
        end
    end

    assign out_data  = dout & dir;
    assign HREADYOUT = 1'b1;

`ifdef AHBGPIO_PARITY_EN
    assign GPIOOUT = {parity17({1'b0, out_data}, PARITYSEL), out_data};
`else
    assign GPIOOUT = {1'b0, out_data};
`endif

    logic unused_bus;
    assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

endmodule
